// File: rtl/serial_link_delay_line.sv
// rtl/serial_link_delay_line.sv - programmable multi-lane delay line with warm-up and stall
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   en_i                advance enable; delay is counted in enabled cycles
//   data_i, valid_i     input lanes (lane 0 in LSBs) and qualifier
//   delay_i             requested delay, loaded by the delay_set_i strobe
//   data_o, valid_o     delayed lanes and qualifier (DefaultVal when invalid and UseDefault=1)
//   delay_o             active delay after clamping to MaxDelay
//   warm_o              high while the line refills after reset or re-programming
module serial_link_delay_line #(
    parameter int                   NumChannels = 1,
    parameter int                   DataWidth   = 8,
    parameter int                   MaxDelay    = 16,
    parameter bit                   UseDefault  = 1'b1,
    parameter logic [DataWidth-1:0] DefaultVal  = '0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              en_i,
    input  logic [NumChannels*DataWidth-1:0]  data_i,
    input  logic                              valid_i,
    input  logic [$clog2(MaxDelay+1)-1:0]     delay_i,
    input  logic                              delay_set_i,
    output logic [NumChannels*DataWidth-1:0]  data_o,
    output logic                              valid_o,
    output logic [$clog2(MaxDelay+1)-1:0]     delay_o,
    output logic                              warm_o
);

    localparam int BusW = NumChannels * DataWidth;
    localparam int DlyW = $clog2(MaxDelay + 1);
    localparam int PtrW = (MaxDelay > 1) ? $clog2(MaxDelay) : 1;
    localparam int SumW = $clog2(2 * MaxDelay) + 1;

    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxDelay - 1);
    localparam logic [DlyW-1:0] MaxD    = DlyW'(MaxDelay);

    typedef enum logic {
        WARM,
        RUN
    } state_t;

    state_t state, state_next;

    logic [BusW-1:0]     data_mem [MaxDelay];
    logic [MaxDelay-1:0] vld_mem;
    logic [PtrW-1:0]     wptr;
    logic [PtrW-1:0]     rd_idx;
    logic [SumW-1:0]     rd_sum;
    logic [DlyW-1:0]     fill, fill_next;
    logic [DlyW-1:0]     delay_q;
    logic [DlyW-1:0]     delay_clamped;
    logic [BusW-1:0]     raw_data;
    logic                raw_valid;

    assign delay_clamped = (delay_i > MaxD) ? MaxD : delay_i;

    // Read index = (wptr - D) mod MaxDelay, computed with a +MaxDelay bias so
    // it never goes negative; one conditional subtract handles the wrap.
    always_comb begin
        rd_sum = SumW'(wptr) + SumW'(MaxDelay) - SumW'(delay_q);
        if (rd_sum >= SumW'(MaxDelay)) begin
            rd_sum = rd_sum - SumW'(MaxDelay);
        end
        rd_idx = rd_sum[PtrW-1:0];
    end

    // D=0 bypasses the buffer; otherwise read the slot before this edge's write,
    // which is what makes D=MaxDelay reach the slot about to be overwritten.
    always_comb begin
        raw_data  = data_mem[rd_idx];
        raw_valid = vld_mem[rd_idx];
        if (delay_q == '0) begin
            raw_data  = data_i;
            raw_valid = valid_i;
        end
    end

    assign data_o  = (UseDefault && !raw_valid) ? {NumChannels{DefaultVal}} : raw_data;
    assign valid_o = raw_valid;
    assign delay_o = delay_q;
    assign warm_o  = (state == WARM);

    // Buffer, write pointer and active delay.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr    <= '0;
            delay_q <= MaxD;
            vld_mem <= '0;
            for (int i = 0; i < MaxDelay; i++) begin
                data_mem[i] <= '0;
            end
        end else begin
            if (delay_set_i) begin
                delay_q <= delay_clamped;
                vld_mem <= '0;
            end
            // Same-cycle write lands after the clear: it is the first new sample.
            if (en_i) begin
                data_mem[wptr] <= data_i;
                vld_mem[wptr]  <= valid_i;
                wptr           <= (wptr == LastPtr) ? '0 : wptr + 1'b1;
            end
        end
    end

    // Warm-up state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= WARM;
            fill  <= '0;
        end else begin
            state <= state_next;
            fill  <= fill_next;
        end
    end

    always_comb begin
        state_next = state;
        fill_next  = fill;
        if (delay_set_i) begin
            fill_next  = en_i ? DlyW'(1) : '0;
            state_next = (delay_clamped == '0) ? RUN : WARM;
        end else if (state == WARM) begin
            if (fill >= delay_q) begin
                state_next = RUN;
            end else if (en_i) begin
                fill_next = fill + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_link_delay_line.sv
// tb/tb_serial_link_delay_line.sv - directed self-checking bench for serial_link_delay_line
module tb_serial_link_delay_line;

    localparam logic [15:0] DEF = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst_i, en_i, valid_i, delay_set_i;
    logic [4:0]  delay_i;
    logic [15:0] data_i;
    logic [15:0] data_o;
    logic        valid_o, warm_o;
    logic [4:0]  delay_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_link_delay_line #(
        .NumChannels(2),
        .DataWidth  (8),
        .MaxDelay   (16),
        .UseDefault (1'b1),
        .DefaultVal (8'hA5)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .delay_i    (delay_i),
        .delay_set_i(delay_set_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .delay_o    (delay_o),
        .warm_o     (warm_o)
    );

    typedef struct {
        bit         rst;
        bit         en;
        bit         set;
        logic [4:0] dly;
        bit         vld;
        logic [7:0] val;
        bit         x_vld;
        logic [7:0] x_val;
        bit         x_warm;
        logic [4:0] x_dly;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [15:0] lane(input logic [7:0] v);
        return {~v, v};
    endfunction

    function automatic logic [15:0] xdata(input bit vld, input logic [7:0] v);
        return vld ? lane(v) : DEF;
    endfunction

    function automatic vec_t mk(input bit r, input bit e, input bit s, input logic [4:0] d,
                                input bit v, input logic [7:0] val, input bit xv,
                                input logic [7:0] xval, input bit xw, input logic [4:0] xd);
        vec_t t;
        t.rst = r; t.en = e; t.set = s; t.dly = d; t.vld = v; t.val = val;
        t.x_vld = xv; t.x_val = xval; t.x_warm = xw; t.x_dly = xd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge; caller samples at the falling edge.
    task automatic apply(input bit r, input bit e, input bit s, input logic [4:0] d,
                         input bit v, input logic [7:0] val);
        rst_i = r; en_i = e; delay_set_i = s; delay_i = d; valid_i = v; data_i = lane(val);
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input bit xv, input logic [7:0] xval);
        chk({name, "_valid"}, 32'(valid_o), 32'(xv));
        chk({name, "_data"}, 32'(data_o), 32'(xdata(xv, xval)));
    endtask

    initial begin
        int e_cnt;
        logic [7:0] samp [32];

        // Row 1 is the delay-3 strobe; sample k lands at row k+1, emerges 3 rows later.
        tbl[0]  = mk(1, 1, 1, 5'd3,  1, 8'hEE, 0, 8'h00, 1, 5'd16);  // reset beats set/en
        tbl[1]  = mk(0, 1, 1, 5'd3,  1, 8'h10, 0, 8'h00, 1, 5'd16);
        tbl[2]  = mk(0, 1, 0, 5'd0,  1, 8'h11, 0, 8'h00, 1, 5'd3);
        tbl[3]  = mk(0, 1, 0, 5'd0,  1, 8'h12, 0, 8'h00, 1, 5'd3);
        tbl[4]  = mk(0, 1, 0, 5'd0,  1, 8'h13, 1, 8'h10, 1, 5'd3);
        tbl[5]  = mk(0, 1, 0, 5'd0,  1, 8'h14, 1, 8'h11, 0, 5'd3);
        tbl[6]  = mk(0, 1, 0, 5'd0,  1, 8'h15, 1, 8'h12, 0, 5'd3);
        tbl[7]  = mk(0, 1, 0, 5'd0,  1, 8'h16, 1, 8'h13, 0, 5'd3);
        tbl[8]  = mk(0, 1, 0, 5'd0,  1, 8'h17, 1, 8'h14, 0, 5'd3);
        tbl[9]  = mk(0, 1, 0, 5'd0,  1, 8'h18, 1, 8'h15, 0, 5'd3);
        tbl[10] = mk(0, 1, 1, 5'd20, 1, 8'h19, 1, 8'h16, 0, 5'd3);   // clamp request
        tbl[11] = mk(0, 1, 0, 5'd0,  1, 8'h1A, 0, 8'h00, 1, 5'd16);
        tbl[12] = mk(0, 1, 1, 5'd0,  1, 8'h1B, 0, 8'h00, 1, 5'd16);  // bypass request
        tbl[13] = mk(0, 1, 0, 5'd0,  1, 8'h60, 1, 8'h60, 0, 5'd0);
        tbl[14] = mk(0, 1, 0, 5'd0,  0, 8'h61, 0, 8'h00, 0, 5'd0);
        tbl[15] = mk(0, 0, 0, 5'd0,  1, 8'h62, 1, 8'h62, 0, 5'd0);
        tbl[16] = mk(0, 0, 0, 5'd0,  1, 8'h63, 1, 8'h63, 0, 5'd0);

        rst_i = 1; en_i = 0; delay_set_i = 0; delay_i = '0; valid_i = 0; data_i = '0;
        next_cycle();

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].set, tbl[i].dly, tbl[i].vld, tbl[i].val);
            chk($sformatf("tbl%0d_valid", i), 32'(valid_o), 32'(tbl[i].x_vld));
            chk($sformatf("tbl%0d_data", i), 32'(data_o), 32'(xdata(tbl[i].x_vld, tbl[i].x_val)));
            chk($sformatf("tbl%0d_warm", i), 32'(warm_o), 32'(tbl[i].x_warm));
            chk($sformatf("tbl%0d_delay", i), 32'(delay_o), 32'(tbl[i].x_dly));
            next_cycle();
        end

        // Max delay over a 40-sample ramp: two pointer wraps.
        for (int k = 0; k < 40; k++) begin
            apply(0, 1, k == 0, 5'd16, 1, 8'(8'h40 + k));
            if (k >= 1) begin
                chk("max_delay", 32'(delay_o), 32'd16);
                chk("max_warm", 32'(warm_o), 32'(k <= 16));
                if (k >= 16) chk_out("max_out", 1, 8'(8'h40 + k - 16));
                else         chk_out("max_out", 0, 8'h00);
            end
            next_cycle();
        end

        // Delay 4 with en pattern 1,0,0: output moves only after enabled edges.
        e_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            bit e;
            e = (k % 3 == 0);
            apply(0, e, k == 0, 5'd4, 1, 8'(8'h80 + k));
            if (k >= 1) begin
                chk("stall_delay", 32'(delay_o), 32'd4);
                if (e_cnt >= 4) chk_out("stall_out", 1, samp[e_cnt - 4]);
                else            chk_out("stall_out", 0, 8'h00);
            end
            if (e) begin
                samp[e_cnt] = 8'(8'h80 + k);
                e_cnt++;
            end
            next_cycle();
        end

        // Stream at delay 5, re-program to 2 at k=12 with en in the strobe cycle.
        for (int k = 0; k < 18; k++) begin
            apply(0, 1, (k == 0) || (k == 12), (k == 0) ? 5'd5 : 5'd2, 1, 8'(8'hC0 + k));
            if (k >= 1 && k <= 12) begin
                chk("reprog_delay5", 32'(delay_o), 32'd5);
                if (k >= 5) chk_out("reprog_old", 1, 8'(8'hC0 + k - 5));
                else        chk_out("reprog_old", 0, 8'h00);
            end else if (k == 13) begin
                chk("reprog_delay2", 32'(delay_o), 32'd2);
                chk("reprog_warm13", 32'(warm_o), 32'd1);
                chk_out("reprog_drop", 0, 8'h00);
            end else if (k == 14) begin
                chk("reprog_warm14", 32'(warm_o), 32'd1);
                chk_out("reprog_first", 1, 8'hCC);
            end else if (k >= 15) begin
                chk("reprog_warm", 32'(warm_o), 32'd0);
                chk_out("reprog_new", 1, 8'(8'hC0 + k - 2));
            end
            next_cycle();
        end

        // Reset for one cycle mid-stream at delay 6.
        for (int k = 0; k < 29; k++) begin
            apply(k == 10, 1, k == 0, 5'd6, 1, 8'(8'h20 + k));
            if (k >= 6 && k <= 10) begin
                chk_out("rst_pre", 1, 8'(8'h20 + k - 6));
            end else if (k == 11) begin
                chk("rst_delay", 32'(delay_o), 32'd16);
                chk("rst_warm", 32'(warm_o), 32'd1);
                chk_out("rst_post", 0, 8'h00);
            end else if (k > 11 && k < 27) begin
                chk_out("rst_no_stale", 0, 8'h00);
            end else if (k == 27) begin
                chk("rst_warm27", 32'(warm_o), 32'd1);
                chk_out("rst_first", 1, 8'h2B);
            end else if (k == 28) begin
                chk("rst_warm28", 32'(warm_o), 32'd0);
                chk_out("rst_second", 1, 8'h2C);
            end
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_link_delay_line.md
# serial_link_delay_line

Synthesizable, cycle-accurate, multi-channel delay line for the serial link's channel and PHY models. It delays a parallel data bus with a valid qualifier by a run-time programmable number of enabled clock cycles, from 0 to MaxDelay. During warm-up it drives a configurable default value. It can replace time-based (`#`) delay insertion in FPGA and emulation builds, and adds stall, valid tracking and re-programming.

## Interface
- NumChannels, default 1: number of independent lanes. All lanes share the same delay.
- DataWidth, default 8: bits per lane.
- MaxDelay, default 16: largest supported delay, ≥1. Buffer depth is MaxDelay entries.
- UseDefault, default 1: when 1, `data_o` drives DefaultVal whenever `valid_o`=0. When 0, `data_o` drives raw buffer contents.
- DefaultVal, default '0: per-lane value of width DataWidth, driven when UseDefault=1 and the output is invalid.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  advance enable. Delay is counted in cycles with en_i=1.
- data_i  in  NumChannels×DataWidth  input lanes, packed with lane 0 in the LSBs.
- valid_i  in  1  input qualifier, stored alongside data.
- delay_i  in  $clog2(MaxDelay+1)  requested delay.
- delay_set_i  in  1  single-cycle strobe that loads delay_i.
- data_o  out  NumChannels×DataWidth  delayed lanes.
- valid_o  out  1  delayed qualifier.
- delay_o  out  $clog2(MaxDelay+1)  active delay, after clamping.
- warm_o  out  1  high while the line is filling after reset or re-programming.

## Operation
- Storage is a ring buffer of MaxDelay entries. Each entry holds data plus a valid bit. A write pointer `wptr` names the next slot to write. Read index = (wptr − D) mod MaxDelay, where D = delay_o.
- Read is combinational from the current buffer contents. Write happens at the clock edge when en_i=1. This read-before-write ordering makes D=MaxDelay legal.
- D=0 is a bypass: data_o=data_i and valid_o=valid_i combinationally. The buffer still writes, warm_o=0, and DefaultVal substitution still applies when valid_i=0 and UseDefault=1.
- Programming delay: on a delay_set_i cycle, delay_o ← min(delay_i, MaxDelay). All buffer valid bits are cleared, the fill counter is cleared, and wptr is kept.
- If en_i=1 in the same cycle as delay_set_i, that cycle's input is written after the clear. It counts as the first sample of the new delay.
- Warm-up state machine:
  - States: WARM and RUN.
  - Reset enters WARM with fill=0.
  - In WARM, each en_i cycle increments fill.
  - The machine moves to RUN when fill reaches D. The transition is immediate if D=0.
  - delay_set_i returns the machine to WARM from any state.
  - warm_o=1 exactly while in WARM.
  - valid_o is always the stored valid bit, so warm-up outputs are invalid because their valid bits were cleared.
- Stall: with en_i=0, wptr, the buffer, fill and the outputs hold. Exception: in bypass mode the outputs follow the inputs.
- delay_i > MaxDelay is clamped to MaxDelay. No error is raised.
- Reset:
  - wptr=0, fill=0, all valid bits=0.
  - delay_o=MaxDelay.
  - warm_o=1.
  - valid_o=0.
  - data_o=DefaultVal when UseDefault=1, otherwise 0. Data storage is reset to 0.
- Reset has priority over delay_set_i and en_i. Reset in mid-stream discards all in-flight samples.

## Timing
- With en_i held at 1, a sample presented in cycle n appears on data_o/valid_o in cycle n+D. With stalls, it appears after D enabled edges.
- delay_o updates one cycle after the delay_set_i strobe. The first valid output can appear D enabled cycles after the strobe cycle's write.
- warm_o deasserts in the cycle after fill reaches D.
- The wptr wrap from MaxDelay−1 to 0 must not disturb the read index.
- Critical path: D-dependent read mux plus DefaultVal select. There are no pipeline registers on the output.

## Test plan
- Reset then delay_set with delay_i=3, continuous en_i, lane value = cycle count with valid → data_o lags by exactly 3 cycles, valid_o=0 and data_o=DefaultVal for the first 3 cycles, warm_o falls after the 3rd enabled cycle.
- delay_i=MaxDelay=16 and 40-cycle ramp → output equals the input 16 cycles earlier across two wraps, no lost or duplicated samples.
- delay_i=0 → data_o tracks data_i in the same cycle and warm_o stays 0. delay_i=20 with MaxDelay=16 → delay_o=16.
- Delay 4 with en_i toggled 1,0,0,1,... → output advances only on enabled cycles, the sample is emitted after 4 enabled edges, and outputs hold during stalls.
- Streaming at delay 5, then delay_set with delay_i=2 mid-stream plus en_i in the same cycle → in-flight samples dropped (valid_o=0), the strobe-cycle sample appears 2 enabled cycles later, warm_o high for 2 cycles.
- rst_i asserted for one cycle mid-stream at delay 6 → next cycle valid_o=0, delay_o=16, warm_o=1, no pre-reset sample ever emitted.
